// File: rtl/cr_tlvp_pkg.sv
// cr_tlvp_pkg: shared types for the TLV parser datapath.
//   tlvp_if_bus_t  - FIFO beat carried between parser stages
//   axi4s_dp_bus_t - beat handed to the next engine's input buffer
//   usm_state_e    - merge-stage FSM encoding
//   TLVP_TUSER_*   - bit positions of sot/eot inside axi4s_dp_bus_t.tuser
package cr_tlvp_pkg;

  localparam int TLVP_DATA_W    = 64;
  localparam int TLVP_STRB_W    = 8;
  localparam int TLVP_TID_W     = 8;
  localparam int TLVP_TUSER_W   = 2;
  localparam int TLVP_TUSER_SOT = 0;
  localparam int TLVP_TUSER_EOT = 1;

  typedef struct packed {
    logic                   sot;
    logic                   eot;
    logic                   insert;
    logic [TLVP_TID_W-1:0]  tid;
    logic [TLVP_STRB_W-1:0] tstrb;
    logic [TLVP_DATA_W-1:0] tdata;
  } tlvp_if_bus_t;

  typedef struct packed {
    logic                    tvalid;
    logic                    tlast;
    logic [TLVP_TID_W-1:0]   tid;
    logic [TLVP_STRB_W-1:0]  tstrb;
    logic [TLVP_DATA_W-1:0]  tdata;
    logic [TLVP_TUSER_W-1:0] tuser;
  } axi4s_dp_bus_t;

  typedef enum logic [1:0] {
    PT_IDLE  = 2'd0,
    PT_BODY  = 2'd1,
    USR_IDLE = 2'd2,
    USR_BODY = 2'd3
  } usm_state_e;

endpackage

// File: rtl/cr_tlvp_usm_ob_reg.sv
// cr_tlvp_usm_ob_reg: output register and merged-TLV counter of the merge stage.
//   i_load            - a beat is accepted this cycle; it appears on o_ob next cycle
//   i_sot/i_eot       - framing of the accepted beat
//   i_tid/i_tstrb/i_tdata - payload copied unchanged
//   o_ob              - registered output beat (all zero when nothing was loaded)
//   o_cnt             - count of emitted eot beats, wraps naturally
import cr_tlvp_pkg::*;

module cr_tlvp_usm_ob_reg #(
  parameter int N_CNT_BITS = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_load,
  input  logic                   i_sot,
  input  logic                   i_eot,
  input  logic [TLVP_TID_W-1:0]  i_tid,
  input  logic [TLVP_STRB_W-1:0] i_tstrb,
  input  logic [TLVP_DATA_W-1:0] i_tdata,
  output axi4s_dp_bus_t          o_ob,
  output logic [N_CNT_BITS-1:0]  o_cnt
);

  axi4s_dp_bus_t          r_ob;
  axi4s_dp_bus_t          w_ob_nxt;
  logic [N_CNT_BITS-1:0]  r_cnt;

  always_comb begin
    w_ob_nxt = '0;
    if (i_load) begin
      w_ob_nxt.tvalid                = 1'b1;
      w_ob_nxt.tlast                 = i_eot;
      w_ob_nxt.tid                   = i_tid;
      w_ob_nxt.tstrb                 = i_tstrb;
      w_ob_nxt.tdata                 = i_tdata;
      w_ob_nxt.tuser[TLVP_TUSER_SOT] = i_sot;
      w_ob_nxt.tuser[TLVP_TUSER_EOT] = i_eot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ob  <= '0;
      r_cnt <= '0;
    end else begin
      r_ob <= w_ob_nxt;
      if (i_load && i_eot) r_cnt <= r_cnt + N_CNT_BITS'(1);
    end
  end

  assign o_ob  = r_ob;
  assign o_cnt = r_cnt;

endmodule

// File: rtl/cr_tlvp2_usm.sv
// cr_tlvp2_usm: merges the pass-through and user-processed TLV FIFOs back into
// one ordered stream. A pass-through TLV carrying an insert marker is followed
// by exactly one user TLV.
//   pt_ob_*        - pass-through FIFO (FWFT head, empty, pop)
//   usr_ob_*       - user FIFO (FWFT head, empty, pop)
//   ob_out         - registered merged beat, one cycle after its pop
//   ob_full/afull  - downstream back-pressure
//   tlvp_usm_error - one-cycle pulse per framing violation
//   merged_tlv_cnt - number of eot beats emitted
//
// state    | meaning
// PT_IDLE  | between TLVs, reading the pass-through FIFO
// PT_BODY  | inside a pass-through TLV, popping until eot
// USR_IDLE | insert pending, waiting for a user TLV start
// USR_BODY | inside a user TLV, popping until eot
import cr_tlvp_pkg::*;

module cr_tlvp2_usm #(
  parameter bit OB_AFULL_STALL = 1'b1,
  parameter int N_CNT_BITS     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  tlvp_if_bus_t          pt_ob_tlv,
  input  logic                  pt_ob_empty,
  output logic                  pt_ob_rd,
  input  tlvp_if_bus_t          usr_ob_tlv,
  input  logic                  usr_ob_empty,
  output logic                  usr_ob_rd,
  output axi4s_dp_bus_t         ob_out,
  input  logic                  ob_full,
  input  logic                  ob_afull,
  output logic                  tlvp_usm_error,
  output logic [N_CNT_BITS-1:0] merged_tlv_cnt
);

  usm_state_e   r_state, w_state_nxt;
  logic         r_ins_pend, w_ins_pend_nxt;
  logic         r_ins_acc, w_ins_acc_nxt;
  logic         r_armed;
  logic         r_err;

  logic         w_stall, w_sel_usr, w_idle, w_empty, w_block;
  logic         w_go, w_discard, w_emit, w_err, w_tlv_ins;
  tlvp_if_bus_t w_head;

  assign w_stall   = ob_full | (OB_AFULL_STALL & ob_afull);
  assign w_sel_usr = (r_state == USR_IDLE) || (r_state == USR_BODY);
  assign w_idle    = (r_state == PT_IDLE)  || (r_state == USR_IDLE);
  assign w_head    = w_sel_usr ? usr_ob_tlv   : pt_ob_tlv;
  assign w_empty   = w_sel_usr ? usr_ob_empty : pt_ob_empty;
  // A pending insert must reach the user side before any pass-through beat moves.
  assign w_block   = (r_state == PT_IDLE) && r_ins_pend;

  // r_armed keeps both pops low until the first edge after reset release.
  assign w_go      = r_armed && !w_stall && !w_empty && !w_block;
  assign w_discard = w_go && w_idle && !w_head.sot;
  assign w_emit    = w_go && !w_discard;
  // sot seen inside a body: the beat still goes out, as a fresh TLV start.
  assign w_err     = w_discard || (w_go && !w_idle && w_head.sot);

  assign pt_ob_rd  = w_go && !w_sel_usr;
  assign usr_ob_rd = w_go &&  w_sel_usr;

  // Insert marker may sit on any beat of the pass-through TLV; it takes effect at eot.
  assign w_tlv_ins = (w_head.sot ? 1'b0 : r_ins_acc) | w_head.insert;

  always_comb begin
    w_state_nxt    = r_state;
    w_ins_pend_nxt = r_ins_pend;
    w_ins_acc_nxt  = r_ins_acc;
    if (w_emit) begin
      if (!w_sel_usr) begin
        if (w_head.eot) begin
          w_state_nxt    = w_tlv_ins ? USR_IDLE : PT_IDLE;
          w_ins_pend_nxt = w_tlv_ins;
          w_ins_acc_nxt  = 1'b0;
        end else begin
          w_state_nxt    = PT_BODY;
          w_ins_acc_nxt  = w_tlv_ins;
        end
      end else if (w_head.eot) begin
        w_state_nxt    = PT_IDLE;
        w_ins_pend_nxt = 1'b0;
      end else begin
        w_state_nxt    = USR_BODY;
      end
    end else if (w_block) begin
      w_state_nxt = USR_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= PT_IDLE;
      r_ins_pend <= 1'b0;
      r_ins_acc  <= 1'b0;
      r_armed    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ins_pend <= w_ins_pend_nxt;
      r_ins_acc  <= w_ins_acc_nxt;
      r_armed    <= 1'b1;
      r_err      <= w_err;
    end
  end

  assign tlvp_usm_error = r_err;

  cr_tlvp_usm_ob_reg #(
    .N_CNT_BITS (N_CNT_BITS)
  ) u_ob_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_emit),
    .i_sot   (w_head.sot),
    .i_eot   (w_head.eot),
    .i_tid   (w_head.tid),
    .i_tstrb (w_head.tstrb),
    .i_tdata (w_head.tdata),
    .o_ob    (ob_out),
    .o_cnt   (merged_tlv_cnt)
  );

endmodule

// File: tb/tb_cr_tlvp2_usm.sv
// tb_cr_tlvp2_usm: directed bench for cr_tlvp2_usm.
// Instance 0 uses default parameters; instance 1 has OB_AFULL_STALL=0 and a
// 4-bit counter. Each instance has its own FWFT FIFO models and output log.
`timescale 1ns/1ps
import cr_tlvp_pkg::*;

module tb_cr_tlvp2_usm;

  localparam logic [2:0] F_S  = 3'b001;  // push flags {insert, eot, sot}
  localparam logic [2:0] F_E  = 3'b010;
  localparam logic [2:0] F_SE = 3'b011;
  localparam logic [2:0] F_M  = 3'b000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tlvp_if_bus_t  pt_tlv[2], usr_tlv[2];
  logic          pt_empty[2], usr_empty[2], pt_rd[2], usr_rd[2];
  logic          full[2], afull[2], err[2];
  axi4s_dp_bus_t ob[2];
  logic [31:0]   cnt0;
  logic [3:0]    cnt1;

  cr_tlvp2_usm u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .pt_ob_tlv(pt_tlv[0]), .pt_ob_empty(pt_empty[0]), .pt_ob_rd(pt_rd[0]),
    .usr_ob_tlv(usr_tlv[0]), .usr_ob_empty(usr_empty[0]), .usr_ob_rd(usr_rd[0]),
    .ob_out(ob[0]), .ob_full(full[0]), .ob_afull(afull[0]),
    .tlvp_usm_error(err[0]), .merged_tlv_cnt(cnt0)
  );

  cr_tlvp2_usm #(.OB_AFULL_STALL(1'b0), .N_CNT_BITS(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .pt_ob_tlv(pt_tlv[1]), .pt_ob_empty(pt_empty[1]), .pt_ob_rd(pt_rd[1]),
    .usr_ob_tlv(usr_tlv[1]), .usr_ob_empty(usr_empty[1]), .usr_ob_rd(usr_rd[1]),
    .ob_out(ob[1]), .ob_full(full[1]), .ob_afull(afull[1]),
    .tlvp_usm_error(err[1]), .merged_tlv_cnt(cnt1)
  );

  // FWFT FIFO models, flushed by rst_n like the real FIFOs
  tlvp_if_bus_t pt_mem[2][256];
  tlvp_if_bus_t usr_mem[2][256];
  logic [7:0]   pt_wp[2]  = '{8'd0, 8'd0};
  logic [7:0]   usr_wp[2] = '{8'd0, 8'd0};
  logic [7:0]   pt_rp[2]  = '{8'd0, 8'd0};
  logic [7:0]   usr_rp[2] = '{8'd0, 8'd0};

  assign pt_tlv[0]    = pt_mem[0][pt_rp[0]];
  assign pt_tlv[1]    = pt_mem[1][pt_rp[1]];
  assign usr_tlv[0]   = usr_mem[0][usr_rp[0]];
  assign usr_tlv[1]   = usr_mem[1][usr_rp[1]];
  assign pt_empty[0]  = (pt_rp[0] == pt_wp[0]);
  assign pt_empty[1]  = (pt_rp[1] == pt_wp[1]);
  assign usr_empty[0] = (usr_rp[0] == usr_wp[0]);
  assign usr_empty[1] = (usr_rp[1] == usr_wp[1]);

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        pt_rp[k]  <= pt_wp[k];
        usr_rp[k] <= usr_wp[k];
      end else begin
        if (pt_rd[k])  pt_rp[k]  <= pt_rp[k] + 8'd1;
        if (usr_rd[k]) usr_rp[k] <= usr_rp[k] + 8'd1;
      end
    end
  end

  // Monitors
  int          cyc         = 0;
  int          pt_pops[2]  = '{0, 0};
  int          usr_pops[2] = '{0, 0};
  int          n_log[2]    = '{0, 0};
  int          n_err[2]    = '{0, 0};
  logic [63:0] log_d[2][128];
  logic [2:0]  log_f[2][128];
  logic [15:0] log_ts[2][128];
  int          log_cyc[2][128];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (pt_rd[k])  pt_pops[k]  <= pt_pops[k] + 1;
      if (usr_rd[k]) usr_pops[k] <= usr_pops[k] + 1;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ob[k].tvalid && n_log[k] < 128) begin
        log_d[k][n_log[k]]   <= ob[k].tdata;
        log_f[k][n_log[k]]   <= {ob[k].tlast, ob[k].tuser[TLVP_TUSER_EOT], ob[k].tuser[TLVP_TUSER_SOT]};
        log_ts[k][n_log[k]]  <= {ob[k].tid, ob[k].tstrb};
        log_cyc[k][n_log[k]] <= cyc;
        n_log[k]             <= n_log[k] + 1;
      end
      if (err[k]) n_err[k] <= n_err[k] + 1;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push(input bit usr, input int k, input logic [2:0] fl, input logic [63:0] d);
    tlvp_if_bus_t b;
    b        = '0;
    b.sot    = fl[0];
    b.eot    = fl[1];
    b.insert = fl[2];
    b.tdata  = d;
    b.tid    = d[7:0] + 8'd1;
    b.tstrb  = ~d[7:0];
    if (usr) begin
      usr_mem[k][usr_wp[k]] = b;
      usr_wp[k] = usr_wp[k] + 8'd1;
    end else begin
      pt_mem[k][pt_wp[k]] = b;
      pt_wp[k] = pt_wp[k] + 8'd1;
    end
  endtask

  // fl = {tlast, tuser[eot], tuser[sot]}
  task automatic exp_beat(input string tag, input int k, input int idx,
                          input logic [63:0] d, input logic [2:0] fl);
    logic [7:0] lo;
    lo = d[7:0];
    if (idx >= n_log[k]) begin
      chk({tag, "_present"}, 128'(n_log[k]), 128'(idx + 1));
    end else begin
      chk({tag, "_data"},  log_d[k][idx], d);
      chk({tag, "_flags"}, log_f[k][idx], fl);
      chk({tag, "_tidstrb"}, log_ts[k][idx], {lo + 8'd1, ~lo});
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1, p0, q0, n0, n1, e0, c0;
    full  = '{1'b0, 1'b0};
    afull = '{1'b0, 1'b0};

    // Reset state
    cyc_wait(3);
    chk("rst_ob",     ob[0],     128'd0);
    chk("rst_pt_rd",  pt_rd[0],  128'd0);
    chk("rst_usr_rd", usr_rd[0], 128'd0);
    chk("rst_err",    err[0],    128'd0);
    chk("rst_cnt",    cnt0,      128'd0);
    rst_n = 1'b1;
    cyc_wait(3);

    // 1/4/2-beat pass-through TLVs on dut0; 17 single-beat TLVs on dut1
    b0 = n_log[0]; b1 = n_log[1]; c0 = cyc;
    push(0, 0, F_SE, 64'h11);
    push(0, 0, F_S,  64'h21); push(0, 0, F_M, 64'h22); push(0, 0, F_M, 64'h23); push(0, 0, F_E, 64'h24);
    push(0, 0, F_S,  64'h31); push(0, 0, F_E, 64'h32);
    for (int i = 0; i < 17; i++) push(0, 1, F_SE, 64'h100 + 64'(i));
    cyc_wait(20);
    exp_beat("s1_b1", 0, b0 + 0, 64'h11, 3'b111);
    exp_beat("s1_b2", 0, b0 + 1, 64'h21, 3'b001);
    exp_beat("s1_b3", 0, b0 + 2, 64'h22, 3'b000);
    exp_beat("s1_b4", 0, b0 + 3, 64'h23, 3'b000);
    exp_beat("s1_b5", 0, b0 + 4, 64'h24, 3'b110);
    exp_beat("s1_b6", 0, b0 + 5, 64'h31, 3'b001);
    exp_beat("s1_b7", 0, b0 + 6, 64'h32, 3'b110);
    chk("s1_beats",   128'(n_log[0] - b0), 128'd7);
    chk("s1_latency", 128'(log_cyc[0][b0] - c0), 128'd1);
    chk("s1_b2b",     128'(log_cyc[0][b0 + 6] - log_cyc[0][b0]), 128'd6);
    chk("s1_cnt",     cnt0, 128'd3);
    chk("wrap_beats", 128'(n_log[1] - b1), 128'd17);
    chk("wrap_cnt",   cnt1, 128'd1);

    // Insert marker with a late user TLV
    b0 = n_log[0];
    push(0, 0, 3'b101, 64'hA0); push(0, 0, F_E, 64'hA1); push(0, 0, F_SE, 64'hB0);
    cyc_wait(3);
    p0 = pt_pops[0];
    cyc_wait(10);
    chk("s2_no_pt_pop",  128'(pt_pops[0] - p0), 128'd0);
    chk("s2_wait_beats", 128'(n_log[0] - b0), 128'd2);
    push(1, 0, F_S, 64'hC0); push(1, 0, F_M, 64'hC1); push(1, 0, F_E, 64'hC2);
    cyc_wait(8);
    exp_beat("s2_a0", 0, b0 + 0, 64'hA0, 3'b001);
    exp_beat("s2_a1", 0, b0 + 1, 64'hA1, 3'b110);
    exp_beat("s2_u0", 0, b0 + 2, 64'hC0, 3'b001);
    exp_beat("s2_u1", 0, b0 + 3, 64'hC1, 3'b000);
    exp_beat("s2_u2", 0, b0 + 4, 64'hC2, 3'b110);
    exp_beat("s2_b0", 0, b0 + 5, 64'hB0, 3'b111);
    chk("s2_cnt", cnt0, 128'd6);

    // ob_afull mid-TLV: dut0 stalls, dut1 ignores it
    b0 = n_log[0]; b1 = n_log[1];
    for (int k = 0; k < 2; k++) begin
      push(0, k, F_S, 64'hD0); push(0, k, F_M, 64'hD1);
      push(0, k, F_M, 64'hD2); push(0, k, F_E, 64'hD3);
    end
    cyc_wait(2);
    afull = '{1'b1, 1'b1};
    p0 = pt_pops[0]; q0 = pt_pops[1]; n0 = n_log[0]; n1 = n_log[1];
    chk("s3_pre_beats", 128'(n0 - b0), 128'd2);
    cyc_wait(5);
    chk("s3_stall_pops",    128'(pt_pops[0] - p0), 128'd0);
    chk("s3_stall_tvalid",  128'(n_log[0] - n0),   128'd0);
    chk("s3_nostall_pops",  128'(pt_pops[1] - q0), 128'd2);
    chk("s3_nostall_beats", 128'(n_log[1] - n1),   128'd2);
    afull = '{1'b0, 1'b0};
    cyc_wait(5);
    for (int k = 0; k < 2; k++) begin
      int bb;
      bb = (k == 0) ? b0 : b1;
      exp_beat("s3_d0", k, bb + 0, 64'hD0, 3'b001);
      exp_beat("s3_d1", k, bb + 1, 64'hD1, 3'b000);
      exp_beat("s3_d2", k, bb + 2, 64'hD2, 3'b000);
      exp_beat("s3_d3", k, bb + 3, 64'hD3, 3'b110);
    end
    chk("s3_cnt0", cnt0, 128'd7);
    chk("s3_cnt1", cnt1, 128'd2);
    chk("s3_no_err", 128'(n_err[0]), 128'd0);

    // Head without sot in PT_IDLE is discarded
    b0 = n_log[0]; e0 = n_err[0]; p0 = pt_pops[0];
    push(0, 0, F_M, 64'hE0); push(0, 0, F_SE, 64'hE1);
    cyc_wait(4);
    chk("s4_err_pulses", 128'(n_err[0] - e0),   128'd1);
    chk("s4_beats",      128'(n_log[0] - b0),   128'd1);
    chk("s4_pops",       128'(pt_pops[0] - p0), 128'd2);
    exp_beat("s4_fwd", 0, b0, 64'hE1, 3'b111);
    chk("s4_cnt", cnt0, 128'd8);

    // Reset during beat 2 of a 4-beat user TLV
    push(0, 0, 3'b111, 64'hF0);
    push(1, 0, F_S, 64'h90); push(1, 0, F_M, 64'h91); push(1, 0, F_M, 64'h92); push(1, 0, F_E, 64'h93);
    cyc_wait(3);
    chk("s5_pre_data", ob[0].tdata, 128'h91);
    rst_n = 1'b0;
    #1;
    chk("s5_rst_ob",     ob[0],     128'd0);
    chk("s5_rst_pt_rd",  pt_rd[0],  128'd0);
    chk("s5_rst_usr_rd", usr_rd[0], 128'd0);
    chk("s5_rst_err",    err[0],    128'd0);
    chk("s5_rst_cnt",    cnt0,      128'd0);
    cyc_wait(2);
    rst_n = 1'b1;
    cyc_wait(2);
    b0 = n_log[0]; q0 = usr_pops[0];
    push(0, 0, F_SE, 64'h55); push(1, 0, F_SE, 64'h66);
    cyc_wait(4);
    exp_beat("s5_after", 0, b0, 64'h55, 3'b111);
    chk("s5_no_usr_pop", 128'(usr_pops[0] - q0), 128'd0);
    chk("s5_cnt", cnt0, 128'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
